// File: rtl/pipe_pkg.sv
// Shared types for the EX->MEM pipeline stage: payload layout and skid buffer states.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch_taken;
        logic [31:0] jump_target;
        logic        jal;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } skid_state_e;

    localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM stage with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Define EX_MEM_PERF_EN to add the stall/flush performance counters.
module ex_mem_skid_stage
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = EX_MEM_PAYLOAD_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
`ifdef EX_MEM_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    skid_state_e          state, state_nxt;
    logic [PAYLOAD_W-1:0] main_q, main_nxt;
    logic [PAYLOAD_W-1:0] skid_q, skid_nxt;
    logic                 in_fire, out_fire;

    // Ready decodes straight from the state flop; nothing from out_ready reaches in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : '0;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    main_nxt  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_nxt = in_data;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    skid_nxt  = in_data;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt = ONE;
                    main_nxt  = skid_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Payload registers may still load on a flush; they are invisible once EMPTY.
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

`ifdef EX_MEM_PERF_EN
    logic cnt_clr;
    assign cnt_clr = reset | perf_clr;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .inc (out_valid & ~out_ready),
        .cnt (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .inc (flush & (state != EMPTY)),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed self-checking bench for ex_mem_skid_stage; perf checks need EX_MEM_PERF_EN.
module tb_ex_mem_skid_stage;
    import pipe_pkg::*;

    localparam int PW = EX_MEM_PAYLOAD_W;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [PW-1:0] in_data, out_data;
`ifdef EX_MEM_PERF_EN
    logic          perf_clr;
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef EX_MEM_PERF_EN
        ,
        .perf_clr  (perf_clr),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    function automatic logic [PW-1:0] pay(input int unsigned n);
        logic [PW-1:0] p;
        p          = '0;
        p[31:0]    = 32'hA500_0000 + n;
        p[63:32]   = ~n;
        p[74:64]   = n[10:0];
        p[106:75]  = 32'h1234_0000 ^ n;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = pay(99); out_ready = 1'b0;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = pay(i);
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            n_cmp++; if (out_data !== pay(i)) begin n_bad++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, pay(i)); end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL bubble_data got %h want 0", out_data); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = pay(101);
        step();
        n_cmp++; if (out_data !== pay(101)) begin n_bad++; $display("FAIL bp_b1_data got %h want %h", out_data, pay(101)); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_one_ready got %b want 1", in_ready); end
        in_data = pay(102);
        step();
        n_cmp++; if (out_data !== pay(101)) begin n_bad++; $display("FAIL bp_full_data got %h want %h", out_data, pay(101)); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        in_data = pay(103);
        step();
        n_cmp++; if (out_data !== pay(101)) begin n_bad++; $display("FAIL bp_hold_data got %h want %h", out_data, pay(101)); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_data !== pay(102)) begin n_bad++; $display("FAIL bp_b2_data got %h want %h", out_data, pay(102)); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_reopen_ready got %b want 1", in_ready); end
        step();
        n_cmp++; if (out_data !== pay(103)) begin n_bad++; $display("FAIL bp_b3_data got %h want %h", out_data, pay(103)); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = pay(201);
        step();
        in_data = pay(202);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_prefull_ready got %b want 0", in_ready); end
        in_data = pay(203); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_full_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_full_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL flush_full_data got %h want 0", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost[%0d] got %b want 0", i, out_valid); end
        end
        // Flush in ONE with a same-cycle accepted beat: that beat must be dropped too.
        out_ready = 1'b0; in_valid = 1'b1; in_data = pay(211);
        step();
        in_data = pay(212); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_one_valid got %b want 0", out_valid); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_one_ghost got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0; in_valid = 1'b1; in_data = pay(301);
        step();
        in_data = pay(302);
        step();
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = pay(401);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== pay(401)) begin n_bad++; $display("FAIL midrst_d1 got %h want %h", out_data, pay(401)); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_alone got %b want 0", out_valid); end
    endtask

`ifdef EX_MEM_PERF_EN
    task automatic test_perf();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL perf_clr_stall got %0d want 0", stall_cnt); end
        n_cmp++; if (flush_cnt !== '0) begin n_bad++; $display("FAIL perf_clr_flush got %0d want 0", flush_cnt); end
        out_ready = 1'b0; in_valid = 1'b1; in_data = pay(501);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL perf_stall_sat got %0d want 15", stall_cnt); end
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL perf_clr_prio got %0d want 0", stall_cnt); end
        flush = 1'b1;
        step();
        n_cmp++; if (flush_cnt !== 4'd1) begin n_bad++; $display("FAIL perf_flush_one got %0d want 1", flush_cnt); end
        step();
        flush = 1'b0;
        n_cmp++; if (flush_cnt !== 4'd1) begin n_bad++; $display("FAIL perf_flush_empty got %0d want 1", flush_cnt); end
    endtask
`endif

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef EX_MEM_PERF_EN
        perf_clr = 1'b0;
`endif
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_midop();
`ifdef EX_MEM_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
